mest_pro_mem_ctrl: RTL and testbench
====================================

# mest_pro_mem_ctrl

Main-memory responder for the MESTPro core. Accepts the load/store requests the execute stage drives (select, chip-select, write-enable, 16-bit address, 8-bit data), services them against an on-chip word array after a configurable number of wait states, and returns read data with a one-cycle completion pulse. Sits between the execute stage and the data storage, on the far end of the execute stage's memory request interface.

## Interface
- ADDR_BITS, 16, request address width; matches the execute-stage memory address width
- DATA_BITS, 8, word width
- MEM_ADDR_BITS, 10, implemented array depth is 2^MEM_ADDR_BITS words
- WAIT_STATES, 2, extra cycles between request capture and array access; legal range 0..15

- clk  input  1  system clock, all state on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_mm_select  input  1  memory request present
- i_cs  input  1  chip select; a request needs i_mm_select && i_cs
- i_we  input  1  1 = store, 0 = load; sampled with the request
- i_mm_addr  input  ADDR_BITS  word address, sampled with the request
- i_mm_dat  input  DATA_BITS  store data, sampled with the request
- o_busy  output  1  high from capture until the request has been serviced and re-armed
- o_done  output  1  one-cycle completion pulse
- o_rd_data  output  DATA_BITS  load result, valid while o_done=1 and held until the next o_done
- o_addr_err  output  1  pulses with o_done when the address is out of range
- o_parity_err  output  1  pulses with o_done on a parity mismatch; constant 0 when parity is not compiled in

## Operation
- FSM states: IDLE, WAIT, ACCESS, REARM.
- IDLE:
  - i_mm_select && i_cs captures i_we, i_mm_addr and i_mm_dat.
  - Next state is WAIT when WAIT_STATES>0, else ACCESS.
  - o_busy goes high.
- WAIT:
  - The 4-bit counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - At 0 the FSM moves to ACCESS.
  - Inputs are ignored; only captured values are used.
- ACCESS:
  - Range check: captured address bits [ADDR_BITS-1:MEM_ADDR_BITS] nonzero = out of range.
    - The array is not accessed.
    - o_addr_err=1 and o_rd_data=0 with o_done.
  - Store: array[addr] written at the edge ending ACCESS.
  - Load: array[addr] registered into o_rd_data at the same edge.
  - o_done=1 for exactly the following cycle.
  - Next state is REARM.
- REARM: stays here until i_mm_select=0 is sampled, then moves to IDLE and drops o_busy. This prevents a request still held by the combinational execute stage from being serviced twice.
- Store followed by load to the same address returns the new data. No read-during-write hazard exists because only one request is in flight.
- Requests arriving while not in IDLE are ignored and not queued.
- Reset:
  - State IDLE, counter 0, o_busy=0, o_done=0, o_rd_data=0, o_addr_err=0, o_parity_err=0.
  - Array contents are not reset.
  - Reset during WAIT or ACCESS aborts the request. A store aborted before its ACCESS edge leaves the array unchanged.

## Timing
- Request sampled at edge E0. ACCESS occupies the cycle after edge E0+WAIT_STATES. o_done is high in the cycle after edge E0+WAIT_STATES+1.
  - WAIT_STATES=0: o_done follows edge E1.
  - WAIT_STATES=2: o_done follows edge E3.
- o_busy rises at E0. It falls at the first edge after o_done where i_mm_select=0 is sampled in REARM, and never earlier than the edge ending the o_done cycle.
- Minimum request-to-request spacing is WAIT_STATES+3 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- MEST_PRO_MEM_PARITY_EN defined:
  - Array width is DATA_BITS+1. An even-parity bit over the data is stored on every store.
  - On a load, a parity mismatch sets o_parity_err with o_done. Data is still returned.
  - Out-of-range accesses never flag parity.
- MEST_PRO_MEM_PARITY_EN undefined: array width is DATA_BITS and o_parity_err is tied to 0.

## Structure
- Package mest_pro_mem_pkg holds:
  - the state enum (IDLE, WAIT, ACCESS, REARM);
  - the default values for ADDR_BITS, DATA_BITS, MEM_ADDR_BITS and WAIT_STATES;
  - the parity helper function.
- Sub-module mest_pro_mem_array is a single-port synchronous array: one write/read port, registered read data, width selected by MEST_PRO_MEM_PARITY_EN, no reset. The controller holds the FSM, counter, range check and output registers.

## Test plan
- Store then load, WAIT_STATES=2: store 0xA5 to 0x0012, drop select, then load 0x0012 -> o_done follows E3 of each request, o_rd_data=0xA5, o_addr_err=0.
- Held select: keep i_mm_select=1 for 10 cycles on one store -> exactly one o_done, o_busy stays high until select drops, one array write.
- Out of range: load 0x0400 with MEM_ADDR_BITS=10 -> o_done with o_addr_err=1 and o_rd_data=0. A following store to 0x0400 leaves array[0x000] unchanged.
- Reset mid-request: store 0x3C to 0x0001 and assert i_reset during WAIT -> all outputs 0, no o_done. A later load of 0x0001 returns the prior contents.
- WAIT_STATES=0 back-to-back: store, 1 idle cycle, load to the same address -> o_done follows E1 of each request, load returns the stored value.
- MEST_PRO_MEM_PARITY_EN: store 0x07 and load it back -> o_parity_err=0. Bench forces the stored parity bit flipped, then loads again -> o_parity_err=1, o_rd_data=0x07.

Source files
------------

// File: rtl/mest_pro_mem_pkg.sv
// Shared types, default sizes and the parity helper for the MESTPro main-memory responder.
// Parity storage is compiled in with MEST_PRO_MEM_PARITY_EN.
package mest_pro_mem_pkg;

  localparam int unsigned AddrBitsDef    = 16;
  localparam int unsigned DataBitsDef    = 8;
  localparam int unsigned MemAddrBitsDef = 10;
  localparam int unsigned WaitStatesDef  = 2;

`ifdef MEST_PRO_MEM_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StRearm
  } mem_state_e;

  // Even parity: the stored bit makes the total count of ones even.
  // Callers zero-extend; padding zeros do not change the result.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mest_pro_mem_array.sv
// Single-port synchronous word array with registered read data and no reset.
// Word width grows by one parity bit when MEST_PRO_MEM_PARITY_EN is defined.
module mest_pro_mem_array
  import mest_pro_mem_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = MemAddrBitsDef,
  parameter int unsigned DATA_BITS     = DataBitsDef,
  localparam int unsigned Width        = DATA_BITS + ParityBits
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [MEM_ADDR_BITS-1:0] addr,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem_q [2**MEM_ADDR_BITS];

  // Read data only moves on a load, so it holds across stores and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/mest_pro_mem_ctrl.sv
// Main-memory responder: captures one request, waits WAIT_STATES cycles, accesses the array,
// pulses o_done and re-arms once select drops. Parity checking via MEST_PRO_MEM_PARITY_EN.
module mest_pro_mem_ctrl
  import mest_pro_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = AddrBitsDef,
  parameter int unsigned DATA_BITS     = DataBitsDef,
  parameter int unsigned MEM_ADDR_BITS = MemAddrBitsDef,
  parameter int unsigned WAIT_STATES   = WaitStatesDef
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_mm_select,
  input  logic                 i_cs,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_mm_addr,
  input  logic [DATA_BITS-1:0] i_mm_dat,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DATA_BITS-1:0] o_rd_data,
  output logic                 o_addr_err,
  output logic                 o_parity_err
);

  localparam int unsigned ArrWidth = DATA_BITS + ParityBits;
  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_e state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 capture;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] dat_q;
  logic                 busy_q, done_q, addr_err_q;
  logic                 rd_hold_q, rd_now_q;
  logic                 in_range, access, arr_en;
  logic [ArrWidth-1:0]  arr_wdata, arr_rdata;

  assign in_range = (addr_q[ADDR_BITS-1:MEM_ADDR_BITS] == '0);
  assign access   = (state_q == StAccess);
  assign arr_en   = access && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_mm_select && i_cs) begin
          capture = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: state_d = StRearm;
      // Hold here while the execute stage still presents the same request.
      StRearm: begin
        if (!i_mm_select) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      rd_hold_q  <= 1'b0;
      rd_now_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= access;
      addr_err_q <= access && !in_range;
      rd_now_q   <= arr_en && !we_q;
      if (capture) begin
        we_q   <= i_we;
        addr_q <= i_mm_addr;
        dat_q  <= i_mm_dat;
      end
      // Out-of-range forces zero read data; an in-range store keeps the last load result.
      if (access) begin
        if (!in_range) begin
          rd_hold_q <= 1'b0;
        end else if (!we_q) begin
          rd_hold_q <= 1'b1;
        end
      end
    end
  end

`ifdef MEST_PRO_MEM_PARITY_EN
  assign arr_wdata    = {even_parity(32'(dat_q)), dat_q};
  assign o_parity_err = done_q && rd_now_q &&
                        (arr_rdata[DATA_BITS] != even_parity(32'(arr_rdata[DATA_BITS-1:0])));
`else
  assign arr_wdata    = dat_q;
  assign o_parity_err = 1'b0;
`endif

  mest_pro_mem_array #(
    .MEM_ADDR_BITS(MEM_ADDR_BITS),
    .DATA_BITS    (DATA_BITS)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (we_q),
    .addr (addr_q[MEM_ADDR_BITS-1:0]),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_addr_err = addr_err_q;
  assign o_rd_data  = rd_hold_q ? arr_rdata[DATA_BITS-1:0] : '0;

endmodule

// File: tb/tb_mest_pro_mem_ctrl.sv
// Bench for mest_pro_mem_ctrl: two instances (WAIT_STATES=2 and 0) share one stimulus stream;
// parity corruption sequence only when MEST_PRO_MEM_PARITY_EN is defined.
module tb_mest_pro_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel, cs, we;
  logic [15:0] addr;
  logic [7:0]  dat;
  logic        busy, done, aerr, perr;
  logic [7:0]  rdata;
  logic        busy0, done0, aerr0, perr0;
  logic [7:0]  rdata0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  dat;
    logic [7:0]  exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic       chk_rd;
    logic [7:0] rd;
    logic       err;
    logic       perr;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  exp_t e_m, e0_m;
  vec_t vecs[12];

  always #5 clk = ~clk;

  mest_pro_mem_ctrl #(.WAIT_STATES(2)) dut (
    .clk         (clk),
    .i_reset     (rst),
    .i_mm_select (sel),
    .i_cs        (cs),
    .i_we        (we),
    .i_mm_addr   (addr),
    .i_mm_dat    (dat),
    .o_busy      (busy),
    .o_done      (done),
    .o_rd_data   (rdata),
    .o_addr_err  (aerr),
    .o_parity_err(perr)
  );

  mest_pro_mem_ctrl #(.WAIT_STATES(0)) dut0 (
    .clk         (clk),
    .i_reset     (rst),
    .i_mm_select (sel),
    .i_cs        (cs),
    .i_we        (we),
    .i_mm_addr   (addr),
    .i_mm_dat    (dat),
    .o_busy      (busy0),
    .o_done      (done0),
    .o_rd_data   (rdata0),
    .o_addr_err  (aerr0),
    .o_parity_err(perr0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: pop one expectation per completion pulse.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done_ws2", 32'd1, 32'd0);
      end else begin
        e_m = q.pop_front();
        if (e_m.chk_rd) check("rd_data_ws2", 32'(rdata), 32'(e_m.rd));
        check("addr_err_ws2", 32'(aerr), 32'(e_m.err));
        check("parity_err_ws2", 32'(perr), 32'(e_m.perr));
      end
    end else if (aerr !== 1'b0 || perr !== 1'b0) begin
      check("err_without_done_ws2", 32'd1, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (!rst && done0 === 1'b1) begin
      if (q0.size() == 0) begin
        check("unexpected_done_ws0", 32'd1, 32'd0);
      end else begin
        e0_m = q0.pop_front();
        if (e0_m.chk_rd) check("rd_data_ws0", 32'(rdata0), 32'(e0_m.rd));
        check("addr_err_ws0", 32'(aerr0), 32'(e0_m.err));
        check("parity_err_ws0", 32'(perr0), 32'(e0_m.perr));
      end
    end else if (aerr0 !== 1'b0 || perr0 !== 1'b0) begin
      check("err_without_done_ws0", 32'd1, 32'd0);
    end
  end

  task automatic push(input logic to_ws2, input logic to_ws0, input logic chk_rd,
                      input logic [7:0] rd, input logic err, input logic p);
    exp_t e;
    e.chk_rd = chk_rd;
    e.rd     = rd;
    e.err    = err;
    e.perr   = p;
    if (to_ws2) q.push_back(e);
    e.perr = 1'b0;
    if (to_ws0) q0.push_back(e);
  endtask

  // One request to both DUTs; select held for `hold` cycles after capture.
  task automatic req(input vec_t v, input int hold, input logic exp_perr);
    int lat, lat0, fall, fall0;
    lat = 0; lat0 = 0; fall = 0; fall0 = 0;
    @(negedge clk);
    sel = 1'b1; cs = 1'b1; we = v.we; addr = v.addr; dat = v.dat;
    push(1'b1, 1'b1, !v.we || v.exp_err, v.exp_rd, v.exp_err, exp_perr);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i >= hold) begin
        sel = 1'b0; cs = 1'b0;
      end else begin
        dat = 8'($urandom);
      end
      if (i == 1) begin
        check("busy_rise_ws2", 32'(busy), 32'd1);
        check("busy_rise_ws0", 32'(busy0), 32'd1);
      end
      if (done && lat == 0) lat = i;
      if (done0 && lat0 == 0) lat0 = i;
      if (lat != 0 && !busy && fall == 0) fall = i;
      if (lat0 != 0 && !busy0 && fall0 == 0) fall0 = i;
      if (fall != 0 && fall0 != 0) break;
    end
    check("latency_ws2", 32'(lat), 32'd4);
    check("latency_ws0", 32'(lat0), 32'd2);
    check("busy_fall_ws2", 32'(fall), 32'((hold > 4 ? hold : 4) + 1));
    check("busy_fall_ws0", 32'(fall0), 32'((hold > 2 ? hold : 2) + 1));
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b1, 16'h0012, 8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 16'h0012, 8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{1'b1, 16'h0000, 8'h5A, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 16'h03FF, 8'hC3, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 16'h03FF, 8'h00, 8'hC3, 1'b0};
    vecs[5]  = '{1'b0, 16'h0400, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 16'h0400, 8'h77, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 16'h0000, 8'h00, 8'h5A, 1'b0};
    vecs[8]  = '{1'b1, 16'h0001, 8'h11, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 16'h0001, 8'h00, 8'h11, 1'b0};
    vecs[10] = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 16'h0012, 8'h00, 8'hA5, 1'b0};

    rst = 1'b1; sel = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; dat = '0;
    repeat (2) @(negedge clk);
    check("reset_outs_ws2", {busy, done, aerr, perr, rdata}, 32'd0);
    check("reset_outs_ws0", {busy0, done0, aerr0, perr0, rdata0}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) req(vecs[i], 1, 1'b0);

    // Held select: one service only, later data changes must not land in the array.
    v = '{1'b1, 16'h0030, 8'h42, 8'h00, 1'b0};
    req(v, 10, 1'b0);
    v = '{1'b0, 16'h0030, 8'h00, 8'h42, 1'b0};
    req(v, 1, 1'b0);

    // Reset while the WS=2 instance is in WAIT (WS=0 is in ACCESS): both abort.
    @(negedge clk);
    sel = 1'b1; cs = 1'b1; we = 1'b1; addr = 16'h0001; dat = 8'h3C;
    @(negedge clk);
    sel = 1'b0; cs = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_outs_ws2", {busy, done, aerr, perr, rdata}, 32'd0);
    check("midreset_outs_ws0", {busy0, done0, aerr0, perr0, rdata0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midreset_no_done", 32'(q.size() + q0.size()), 32'd0);
    v = '{1'b0, 16'h0001, 8'h00, 8'h11, 1'b0};
    req(v, 1, 1'b0);

    // Back-to-back on WS=0 with one idle cycle; WS=2 is still busy and ignores the load.
    @(negedge clk);
    sel = 1'b1; cs = 1'b1; we = 1'b1; addr = 16'h0020; dat = 8'h99;
    push(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    sel = 1'b0; cs = 1'b0;
    @(negedge clk);
    check("b2b_store_done_ws0", 32'(done0), 32'd1);
    @(negedge clk);
    sel = 1'b1; cs = 1'b1; we = 1'b0; addr = 16'h0020; dat = 8'h00;
    push(1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    @(negedge clk);
    sel = 1'b0; cs = 1'b0;
    check("b2b_store_done_ws2", 32'(done), 32'd1);
    @(negedge clk);
    check("b2b_load_done_ws0", 32'(done0), 32'd1);
    repeat (6) @(negedge clk);
    check("b2b_ws2_busy_clear", 32'(busy), 32'd0);

`ifdef MEST_PRO_MEM_PARITY_EN
    v = '{1'b1, 16'h0007, 8'h07, 8'h00, 1'b0};
    req(v, 1, 1'b0);
    v = '{1'b0, 16'h0007, 8'h00, 8'h07, 1'b0};
    req(v, 1, 1'b0);
    dut.u_array.mem_q[7][8] = ~dut.u_array.mem_q[7][8];
    req(v, 1, 1'b1);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(q.size() + q0.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
